// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result producers, the arbiter and the
// register-file write port.
//
// Signals:
//   a_valid/a_reg/a_data, a_ready  - requester A (ALU result path)
//   b_valid/b_reg/b_data, b_ready  - requester B (load / multi-cycle path)
//   RegWrite/Write_register/Write_data - registered register-file write port
//
// Modports:
//   master - requester / register-file side (drives requests, observes port)
//   slave  - arbiter side (accepts requests, drives readies and write port)
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_data;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, RegWrite, Write_register, Write_data
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, RegWrite, Write_register, Write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
//
// Shares the single register-file write port between the ALU result path (A)
// and the load / multi-cycle result path (B). A has fixed priority. The
// winning request is captured into the output register and appears on the
// write port in the following cycle; back-to-back grants give back-to-back
// writes. Writes addressed to register 0 complete the handshake but keep
// RegWrite low.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset; readies are held low while asserted
//   wb    - regfile_wb_arbiter_if.slave (requests, readies, write port)
//
// Build option:
//   WB_AGE_EN - adds an age counter for B. After B has been blocked for
//               MAX_WAIT consecutive cycles it is granted ahead of A for one
//               cycle. Without it B can starve while A stays valid.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb
);

  logic              force_b;
  logic              a_xfer;
  logic              b_xfer;
  logic              we_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;

  // Readies never look at the requester's own valid, and A's valid only
  // gates B, so both can be high together only when A is idle.
  assign wb.a_ready = reset & ~force_b;
  assign wb.b_ready = reset & (~wb.a_valid | force_b);

  assign a_xfer = wb.a_valid & wb.a_ready;
  assign b_xfer = wb.b_valid & wb.b_ready;

`ifdef WB_AGE_EN
  localparam int                AGE_W   = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age_q;

  // Counts consecutive cycles B is held off; restarts whenever B is idle
  // or finally gets through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= '0;
    end else if (!wb.b_valid || b_xfer) begin
      age_q <= '0;
    end else if (age_q != AGE_MAX) begin
      age_q <= age_q + 1'b1;
    end
  end

  assign force_b = (age_q == AGE_MAX);
`else
  localparam int unused_max_wait = MAX_WAIT;

  assign force_b = 1'b0;
`endif

  // a_xfer and b_xfer are mutually exclusive: B only sees ready with A
  // idle or forced, and a forced cycle withdraws A's ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else if (a_xfer) begin
      we_q    <= |wb.a_reg;
      wreg_q  <= wb.a_reg;
      wdata_q <= wb.a_data;
    end else if (b_xfer) begin
      we_q    <= |wb.b_reg;
      wreg_q  <= wb.b_reg;
      wdata_q <= wb.b_data;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign wb.RegWrite       = we_q;
  assign wb.Write_register = wreg_q;
  assign wb.Write_data     = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;

`ifdef WB_AGE_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    string       nm;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write-port monitor: each cycle, compare the port against the entry
  // scheduled for it by the stimulus.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: entry for cycle %0d not checked, now %0d", e.nm, e.cyc, cyc);
      end else begin
        chk({e.nm, " RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, e.we});
        chk({e.nm, " Write_register"}, {27'd0, bus.Write_register}, {27'd0, e.wr});
        chk({e.nm, " Write_data"}, bus.Write_data, e.wd);
      end
    end
  end

  task automatic step(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic bv, input logic [4:0] br, input logic [31:0] bd,
    input logic ear, input logic ebr,
    input logic ewe, input logic [4:0] ewr, input logic [31:0] ewd,
    input string nm
  );
    exp_t e;
    @(negedge clk);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    #1;
    chk({nm, " a_ready"}, {31'd0, bus.a_ready}, {31'd0, ear});
    chk({nm, " b_ready"}, {31'd0, bus.b_ready}, {31'd0, ebr});
    e.cyc = cyc + 1; e.we = ewe; e.wr = ewr; e.wd = ewd; e.nm = nm;
    sbq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.a_valid = 1'b1; bus.a_reg = 5'd1; bus.a_data = 32'h1111_1111;
    bus.b_valid = 1'b1; bus.b_reg = 5'd2; bus.b_data = 32'h2222_2222;

    // Reset state while both requesters are valid.
    @(posedge clk); #2;
    chk("rst RegWrite", {31'd0, bus.RegWrite}, 32'd0);
    chk("rst Write_register", {27'd0, bus.Write_register}, 32'd0);
    chk("rst Write_data", bus.Write_data, 32'd0);
    chk("rst a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("rst b_ready", {31'd0, bus.b_ready}, 32'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    reset = 1'b1;

    // Single A write, accepted at the first edge after reset release.
    step(1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0, 1, 0, 1, 5'd5, 32'h1234_5678, "a_single");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd5, 32'h1234_5678, "a_single_idle");

    // Same-register conflict: A first, then B.
    step(1, 5'd3, 32'h0000_AAAA, 1, 5'd3, 32'h0000_BBBB, 1, 0, 1, 5'd3, 32'h0000_AAAA, "conf_a");
    step(0, 5'd0, 32'h0, 1, 5'd3, 32'h0000_BBBB, 1, 1, 1, 5'd3, 32'h0000_BBBB, "conf_b");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd3, 32'h0000_BBBB, "conf_idle");

    // Register 0: handshake completes, no write enable.
    step(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, 1, 0, 0, 5'd0, 32'hFFFF_FFFF, "a_r0");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd0, 32'hFFFF_FFFF, "a_r0_idle");

    // B alone, then B to register 0.
    step(0, 5'd0, 32'h0, 1, 5'd9, 32'hCAFE_F00D, 1, 1, 1, 5'd9, 32'hCAFE_F00D, "b_single");
    step(0, 5'd0, 32'h0, 1, 5'd0, 32'h0BAD_0BAD, 1, 1, 0, 5'd0, 32'h0BAD_0BAD, "b_r0");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd0, 32'h0BAD_0BAD, "b_idle");

    // A and B continuously valid for four cycles: A wins each time.
    for (int i = 0; i < 4; i++) begin
      step(1, 5'(10 + i), 32'h100 + i, 1, 5'd20, 32'hDEAD_0020,
           1, 0, 1, 5'(10 + i), 32'h100 + i, $sformatf("cont%0d", i));
    end
    // A drops; with aging B has also reached its limit here.
    step(0, 5'd0, 32'h0, 1, 5'd20, 32'hDEAD_0020, !AGE, 1, 1, 5'd20, 32'hDEAD_0020, "cont_b");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd20, 32'hDEAD_0020, "cont_idle");

`ifdef WB_AGE_EN
    // Twelve cycles of contention: B forced through on cycles 5 and 10.
    for (int i = 1; i <= 12; i++) begin
      if (i == 5 || i == 10)
        step(1, 5'(i), 32'h100 + i, 1, 5'd20, 32'hDEAD_0020,
             0, 1, 1, 5'd20, 32'hDEAD_0020, $sformatf("age%0d", i));
      else
        step(1, 5'(i), 32'h100 + i, 1, 5'd20, 32'hDEAD_0020,
             1, 0, 1, 5'(i), 32'h100 + i, $sformatf("age%0d", i));
    end
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd12, 32'h10C, "age_idle");
`endif

    // Reset asserted while a write is on the port.
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_reg = 5'd7; bus.a_data = 32'h0000_0077;
    bus.b_valid = 1'b1; bus.b_reg = 5'd8; bus.b_data = 32'h0000_0088;
    @(posedge clk); #1;
    chk("mid RegWrite before", {31'd0, bus.RegWrite}, 32'd1);
    chk("mid Write_register before", {27'd0, bus.Write_register}, 32'd7);
    #1 reset = 1'b0;
    #1;
    chk("mid RegWrite", {31'd0, bus.RegWrite}, 32'd0);
    chk("mid Write_register", {27'd0, bus.Write_register}, 32'd0);
    chk("mid Write_data", bus.Write_data, 32'd0);
    chk("mid a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("mid b_ready", {31'd0, bus.b_ready}, 32'd0);
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd0, 32'h0, "post_rst_idle");
    step(1, 5'd31, 32'h5A5A_A5A5, 0, 5'd0, 32'h0, 1, 0, 1, 5'd31, 32'h5A5A_A5A5, "post_rst_a");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd31, 32'h5A5A_A5A5, "post_rst_end");

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / Write_register / Write_data) between two writeback requesters.
- Requester A is the ALU result path; requester B is the load/multi-cycle unit result path.
- Each requester uses a valid/ready handshake. The block registers the winning write and drives the register-file write port one cycle later.
- Sits between execute/memory writeback sources and the register file in the CPU datapath.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- MAX_WAIT, 4, number of cycles B may be blocked before it is forced through. Used only with WB_AGE_EN.

Ports:
- clk  input  1  clock, rising edge active.
- reset  input  1  asynchronous, active-low reset.
- a_valid  input  1  A has a write pending.
- a_reg  input  ADDR_W  A destination register.
- a_data  input  DATA_W  A write data.
- a_ready  output  1  A transfer accepted this cycle.
- b_valid  input  1  B has a write pending.
- b_reg  input  ADDR_W  B destination register.
- b_data  input  DATA_W  B write data.
- b_ready  output  1  B transfer accepted this cycle.
- RegWrite  output  1  register-file write enable (registered).
- Write_register  output  ADDR_W  register-file write index (registered).
- Write_data  output  DATA_W  register-file write data (registered).

Behaviour:
- Reset (reset=0, asynchronous):
  - RegWrite=0, Write_register=0, Write_data=0.
  - Age counter = 0.
  - a_ready=0 and b_ready=0 while reset is low.
  - Any in-flight write is discarded.
- Transfer rule: a transfer occurs on a rising clk edge when valid && ready.
- Ready generation is combinational and does not depend on the requester's own valid:
  - a_ready = !force_b
  - b_ready = !a_valid || force_b
- force_b is 0 unless WB_AGE_EN is defined.
- The two ready outputs are never both 1 while a_valid=1 and b_valid=1.
- Latency: transfer at edge N puts the write on the port during cycle N+1. The register file captures it at edge N+1.
- RegWrite is 1 for exactly one cycle per transfer and falls back to 0 when no transfer occurs.
- Back-to-back transfers give back-to-back RegWrite cycles. There is no bubble and no throughput loss.
- Write_register / Write_data:
  - Updated only on a transfer.
  - Hold their last value otherwise.
- Writes to register 0:
  - The handshake completes normally (ready asserted, requester released).
  - RegWrite stays 0 for that cycle.
  - Write_register / Write_data still update.
- Same-register conflict: A and B both valid to the same index → A wins; B is written in a later cycle. The final register value is B's data, matching program order (load completes after ALU op).
- No buffering beyond the single output register. Requesters must hold reg/data stable while valid && !ready.
- Reset mid-operation clears everything immediately. After deassertion the first transfer can occur at the first rising edge.

Optional Feature:
- Macro: WB_AGE_EN.
- Defined:
  - Adds a $clog2(MAX_WAIT+1)-bit age counter.
  - The counter increments (saturating at MAX_WAIT) each edge where b_valid && !b_ready.
  - It clears on a B transfer or when b_valid=0.
  - force_b = (counter == MAX_WAIT): b_ready=1 and a_ready=0 for that cycle.
  - After the forced B transfer the counter clears and A regains priority.
- Not defined:
  - No counter is implemented and force_b is tied to 0.
  - Strict fixed priority applies: A always wins, and B may starve while A is continuously valid.

Test Plan:
- Assert reset=0 mid-stream while RegWrite=1 → RegWrite, Write_register and Write_data go to 0 without a clock edge, and a_ready=b_ready=0. Deassert → idle: RegWrite=0.
- a_valid=1, a_reg=5, a_data=0x12345678 for one cycle → a_ready=1. Next cycle RegWrite=1, Write_register=5, Write_data=0x12345678. The cycle after, RegWrite=0.
- a_valid=b_valid=1 with a_reg=b_reg=3, a_data=0x0000AAAA, b_data=0x0000BBBB; A drops after accept:
  - cycle1: a_ready=1, b_ready=0.
  - cycle2: write of 0x0000AAAA to reg 3; b_ready=1.
  - cycle3: write of 0x0000BBBB to reg 3.
- a_valid=1, a_reg=0, a_data=0xFFFFFFFF → a_ready=1. Next cycle RegWrite=0 and Write_register=0.
- A and B valid continuously for 4 cycles:
  - without WB_AGE_EN: a_ready=1 every cycle; RegWrite=1 on four consecutive cycles, all with A's data; b_ready=0 throughout.
- WB_AGE_EN, MAX_WAIT=4; a_valid and b_valid held high for 12 cycles:
  - b_ready=1 and a_ready=0 on cycle 5 and again on cycle 10.
  - a_ready=1 on all other cycles.
  - Write data order shows B's data one cycle after each forced grant.
